// File: rtl/cp0_tlb_pkg.sv
// CP0 TLB register numbers, write masks and field positions.
// TLB_CONTEXT_EN adds the Context write mask and BadVPN2 field constants.
package cp0_tlb_pkg;

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_CONTEXT  = 5'd4;
    localparam logic [4:0] REG_PAGEMASK = 5'd5;
    localparam logic [4:0] REG_WIRED    = 5'd6;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;

    localparam logic [31:0] ENTRYLO_MASK  = 32'h3FFF_FFFF;
    localparam logic [31:0] PAGEMASK_MASK = 32'h1FFF_E000;
    localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;
    localparam logic [31:0] INDEX_P_MASK  = 32'h8000_0000;

    localparam int unsigned INDEX_P_BIT = 31;
    localparam int unsigned VPN2_HI     = 31;
    localparam int unsigned VPN2_LO     = 13;
    localparam int unsigned ASID_HI     = 7;
    localparam int unsigned ASID_LO     = 0;

`ifdef TLB_CONTEXT_EN
    localparam logic [31:0] CONTEXT_MASK = 32'hFF80_0000;
    localparam int unsigned BADVPN2_HI   = 22;
    localparam int unsigned BADVPN2_LO   = 4;
`endif

endpackage

// File: rtl/cp0_tlb_regs_if.sv
// CP0 <-> MMU / commit-stage bundle for the TLB-management registers.
interface cp0_tlb_regs_if;

    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        tlbp;
    logic        tlbr;
    logic [31:0] mmu_index;
    logic [31:0] mmu_pagemask;
    logic [31:0] mmu_entryhi;
    logic [31:0] mmu_entrylo0;
    logic [31:0] mmu_entrylo1;
    logic        exc_tlb;
    logic        exc_addr;
    logic [31:0] exc_vaddr;
    logic [31:0] pagemask;
    logic [31:0] entrylo0;
    logic [31:0] entrylo1;
    logic [31:0] entryhi;
    logic [31:0] index;
    logic [31:0] random;

    modport master (
        output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, tlbp, tlbr,
               mmu_index, mmu_pagemask, mmu_entryhi, mmu_entrylo0, mmu_entrylo1,
               exc_tlb, exc_addr, exc_vaddr,
        input  mfc0_rdata, pagemask, entrylo0, entrylo1, entryhi, index, random
    );

    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, tlbp, tlbr,
               mmu_index, mmu_pagemask, mmu_entryhi, mmu_entrylo0, mmu_entrylo1,
               exc_tlb, exc_addr, exc_vaddr,
        output mfc0_rdata, pagemask, entrylo0, entrylo1, entryhi, index, random
    );

endinterface

// File: rtl/cp0_random_counter.sv
// Random down-counter: wraps to the top when it reaches Wired, reloads on a Wired write.
module cp0_random_counter #(
    parameter int unsigned TLB_LINE  = 32,
    parameter int unsigned TLB_WIDTH = $clog2(TLB_LINE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wired_we_i,
    input  logic [TLB_WIDTH-1:0] wired_i,
    output logic [TLB_WIDTH-1:0] random_o
);

    localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_LINE - 1);

    logic [TLB_WIDTH-1:0] random_q;
    logic [TLB_WIDTH-1:0] random_d;

    // Wired at the top leaves no random slots, so the counter parks there.
    always_comb begin
        random_d = random_q - TLB_WIDTH'(1);
        if (wired_we_i || (wired_i >= RAND_TOP) || (random_q == wired_i)) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB-management register file feeding the MMU; MTC0/MFC0, TLBP/TLBR and exception capture.
// Define TLB_CONTEXT_EN to implement the Context register (reg 4); otherwise it reads 0.
module cp0_tlb_regs
    import cp0_tlb_pkg::*;
#(
    parameter int unsigned TLB_LINE  = 32,
    parameter int unsigned TLB_WIDTH = $clog2(TLB_LINE)
) (
    input  logic           clk,
    input  logic           rst,
    cp0_tlb_regs_if.slave  bus
);

    localparam logic [31:0] INDEX_MASK = 32'(TLB_LINE - 1);
    localparam logic [31:0] WIRED_MASK = 32'(TLB_LINE - 1);

    logic [31:0] index_q,    index_d;
    logic [31:0] entrylo0_q, entrylo0_d;
    logic [31:0] entrylo1_q, entrylo1_d;
    logic [31:0] pagemask_q, pagemask_d;
    logic [31:0] wired_q,    wired_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] entryhi_q,  entryhi_d;
    logic [31:0] context_q;
    logic [TLB_WIDTH-1:0] random_w;
    logic [31:0] rdata_c;

    logic wr_index, wr_lo0, wr_lo1, wr_pagemask, wr_wired, wr_entryhi;
    logic tlbp_only;

    assign wr_index    = bus.mtc0_we && (bus.mtc0_addr == REG_INDEX);
    assign wr_lo0      = bus.mtc0_we && (bus.mtc0_addr == REG_ENTRYLO0);
    assign wr_lo1      = bus.mtc0_we && (bus.mtc0_addr == REG_ENTRYLO1);
    assign wr_pagemask = bus.mtc0_we && (bus.mtc0_addr == REG_PAGEMASK);
    assign wr_wired    = bus.mtc0_we && (bus.mtc0_addr == REG_WIRED);
    assign wr_entryhi  = bus.mtc0_we && (bus.mtc0_addr == REG_ENTRYHI);

    // A TLBR on the same edge suppresses TLBP.
    assign tlbp_only = bus.tlbp && !bus.tlbr;

    // Next-state: exception over TLB op over MTC0, per register.
    always_comb begin
        index_d    = index_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        pagemask_d = pagemask_q;
        wired_d    = wired_q;
        badvaddr_d = badvaddr_q;
        entryhi_d  = entryhi_q;

        if (tlbp_only) begin
            index_d = bus.mmu_index[INDEX_P_BIT] ? INDEX_P_MASK : (bus.mmu_index & INDEX_MASK);
        end else if (wr_index) begin
            index_d = bus.mtc0_wdata & INDEX_MASK;
        end

        if (bus.tlbr) begin
            entrylo0_d = bus.mmu_entrylo0 & ENTRYLO_MASK;
            entrylo1_d = bus.mmu_entrylo1 & ENTRYLO_MASK;
            pagemask_d = bus.mmu_pagemask & PAGEMASK_MASK;
        end else begin
            if (wr_lo0)      entrylo0_d = bus.mtc0_wdata & ENTRYLO_MASK;
            if (wr_lo1)      entrylo1_d = bus.mtc0_wdata & ENTRYLO_MASK;
            if (wr_pagemask) pagemask_d = bus.mtc0_wdata & PAGEMASK_MASK;
        end

        if (wr_wired) begin
            wired_d = bus.mtc0_wdata & WIRED_MASK;
        end

        if (bus.exc_tlb || bus.exc_addr) begin
            badvaddr_d = bus.exc_vaddr;
        end

        if (bus.exc_tlb) begin
            entryhi_d = {bus.exc_vaddr[VPN2_HI:VPN2_LO], 5'b0, entryhi_q[ASID_HI:ASID_LO]};
        end else if (bus.tlbr) begin
            entryhi_d = bus.mmu_entryhi & ENTRYHI_MASK;
        end else if (wr_entryhi) begin
            entryhi_d = bus.mtc0_wdata & ENTRYHI_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q    <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            pagemask_q <= '0;
            wired_q    <= '0;
            badvaddr_q <= '0;
            entryhi_q  <= '0;
        end else begin
            index_q    <= index_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            pagemask_q <= pagemask_d;
            wired_q    <= wired_d;
            badvaddr_q <= badvaddr_d;
            entryhi_q  <= entryhi_d;
        end
    end

`ifdef TLB_CONTEXT_EN
    logic [31:0] context_d;
    logic        wr_context;

    assign wr_context = bus.mtc0_we && (bus.mtc0_addr == REG_CONTEXT);

    // BadVPN2 is hardware-owned; PTEBase is software-owned.
    always_comb begin
        context_d = context_q;
        if (bus.exc_tlb) begin
            context_d = {context_q[31:BADVPN2_HI+1], bus.exc_vaddr[VPN2_HI:VPN2_LO],
                         BADVPN2_LO'(0)};
        end else if (wr_context) begin
            context_d = (bus.mtc0_wdata & CONTEXT_MASK) | (context_q & ~CONTEXT_MASK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            context_q <= '0;
        end else begin
            context_q <= context_d;
        end
    end
`else
    assign context_q = '0;
`endif

    cp0_random_counter #(
        .TLB_LINE  (TLB_LINE),
        .TLB_WIDTH (TLB_WIDTH)
    ) u_random (
        .clk        (clk),
        .rst        (rst),
        .wired_we_i (wr_wired),
        .wired_i    (wired_q[TLB_WIDTH-1:0]),
        .random_o   (random_w)
    );

    always_comb begin
        rdata_c = '0;
        case (bus.mfc0_addr)
            REG_INDEX:    rdata_c = index_q;
            REG_RANDOM:   rdata_c = 32'(random_w);
            REG_ENTRYLO0: rdata_c = entrylo0_q;
            REG_ENTRYLO1: rdata_c = entrylo1_q;
            REG_CONTEXT:  rdata_c = context_q;
            REG_PAGEMASK: rdata_c = pagemask_q;
            REG_WIRED:    rdata_c = wired_q;
            REG_BADVADDR: rdata_c = badvaddr_q;
            REG_ENTRYHI:  rdata_c = entryhi_q;
            default:      rdata_c = '0;
        endcase
    end

    assign bus.mfc0_rdata = rdata_c;
    assign bus.index      = index_q;
    assign bus.random     = 32'(random_w);
    assign bus.entrylo0   = entrylo0_q;
    assign bus.entrylo1   = entrylo1_q;
    assign bus.pagemask   = pagemask_q;
    assign bus.entryhi    = entryhi_q;

    tlbp_tlbr_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.tlbp && bus.tlbr));

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Directed checks of the CP0 TLB register file; expected values are hand-computed.
module tb_cp0_tlb_regs;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [31:0] exp_rand;
    logic [31:0] ctx_a, ctx_b, ctx_c;

    cp0_tlb_regs_if bus_if();

    cp0_tlb_regs #(.TLB_LINE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus_if.mfc0_addr = a;
        #1;
        chk(tag, bus_if.mfc0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus_if.mtc0_we    = 1'b1;
        bus_if.mtc0_addr  = a;
        bus_if.mtc0_wdata = d;
        tick();
        bus_if.mtc0_we    = 1'b0;
    endtask

    task automatic tlbp(input logic [31:0] v);
        bus_if.tlbp      = 1'b1;
        bus_if.mmu_index = v;
        tick();
        bus_if.tlbp      = 1'b0;
    endtask

    task automatic exc(input logic tlb, input logic [31:0] v);
        bus_if.exc_tlb   = tlb;
        bus_if.exc_addr  = !tlb;
        bus_if.exc_vaddr = v;
        tick();
        bus_if.exc_tlb   = 1'b0;
        bus_if.exc_addr  = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
`ifdef TLB_CONTEXT_EN
        ctx_a = 32'hFF80_0000;
        ctx_b = 32'hFF89_1A20;
        ctx_c = 32'hFFD5_E6F0;
`else
        ctx_a = 32'h0;
        ctx_b = 32'h0;
        ctx_c = 32'h0;
`endif
        rst = 1'b1;
        bus_if.mtc0_we = 1'b0;   bus_if.mtc0_addr = '0;    bus_if.mtc0_wdata = '0;
        bus_if.mfc0_addr = '0;   bus_if.tlbp = 1'b0;       bus_if.tlbr = 1'b0;
        bus_if.mmu_index = '0;   bus_if.mmu_pagemask = '0; bus_if.mmu_entryhi = '0;
        bus_if.mmu_entrylo0 = '0; bus_if.mmu_entrylo1 = '0;
        bus_if.exc_tlb = 1'b0;   bus_if.exc_addr = 1'b0;   bus_if.exc_vaddr = '0;

        // Reset state
        #12;
        chk("rst_random_out", bus_if.random, 32'd31);
        chk("rst_index", bus_if.index, 32'h0);
        chk("rst_entryhi", bus_if.entryhi, 32'h0);
        chk("rst_pagemask", bus_if.pagemask, 32'h0);
        chk("rst_entrylo0", bus_if.entrylo0, 32'h0);
        chk("rst_entrylo1", bus_if.entrylo1, 32'h0);
        rd(5'd1, 32'd31, "rst_mfc0_random");
        rd(5'd8, 32'h0, "rst_badvaddr");
        rst = 1'b0;
        repeat (5) tick();
        rd(5'd1, 32'd26, "random_after_5");

        // Wired floor and wrap
        mtc0(5'd6, 32'd4);
        chk("wired_reload", bus_if.random, 32'd31);
        rd(5'd6, 32'd4, "wired_read");
        exp_rand = 32'd31;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_rand = (exp_rand == 32'd4) ? 32'd31 : exp_rand - 32'd1;
            chk("random_seq", bus_if.random, exp_rand);
        end

        // Write masks
        mtc0(5'd10, 32'hFFFF_FFFF);
        rd(5'd10, 32'hFFFF_E0FF, "entryhi_mask");
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, 32'h1FFF_E000, "pagemask_mask");
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, 32'h3FFF_FFFF, "entrylo1_mask");
        mtc0(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 32'h0000_001F, "index_mask");
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd(5'd7, 32'h0, "unimpl_reg7");
        mtc0(5'd4, 32'hFFFF_FFFF);
        rd(5'd4, ctx_a, "context_mask");

        // Wired at top pins Random
        mtc0(5'd6, 32'hFFFF_FFFF);
        rd(5'd6, 32'h1F, "wired_mask");
        repeat (3) tick();
        chk("random_pinned", bus_if.random, 32'd31);
        mtc0(5'd6, 32'h0);
        chk("random_reload_w0", bus_if.random, 32'd31);
        tick();
        chk("random_dec_w0", bus_if.random, 32'd30);

        // TLBP
        tlbp(32'h8000_0000);
        chk("tlbp_miss", bus_if.index, 32'h8000_0000);
        tlbp(32'h8000_0013);
        rd(5'd0, 32'h8000_0000, "tlbp_miss_masked");
        tlbp(32'h0000_0007);
        chk("tlbp_hit", bus_if.index, 32'h0000_0007);
        bus_if.mtc0_we = 1'b1; bus_if.mtc0_addr = 5'd0; bus_if.mtc0_wdata = 32'd9;
        tlbp(32'h0000_0005);
        bus_if.mtc0_we = 1'b0;
        chk("tlbp_over_mtc0", bus_if.index, 32'h0000_0005);

        // TLB exception captures
        mtc0(5'd10, 32'h0000_003A);
        chk("entryhi_asid", bus_if.entryhi, 32'h0000_003A);
        exc(1'b1, 32'h1234_5678);
        rd(5'd8, 32'h1234_5678, "exc_tlb_badvaddr");
        chk("exc_tlb_entryhi", bus_if.entryhi, 32'h1234_403A);
        rd(5'd4, ctx_b, "exc_tlb_context");
        exc(1'b0, 32'hDEAD_BEEF);
        rd(5'd8, 32'hDEAD_BEEF, "exc_addr_badvaddr");
        chk("exc_addr_entryhi", bus_if.entryhi, 32'h1234_403A);

        // Exception beats MTC0 on EntryHi
        bus_if.mtc0_we = 1'b1; bus_if.mtc0_addr = 5'd10; bus_if.mtc0_wdata = 32'h0;
        exc(1'b1, 32'hABCD_E123);
        bus_if.mtc0_we = 1'b0;
        chk("exc_over_mtc0", bus_if.entryhi, 32'hABCD_E03A);
        rd(5'd4, ctx_c, "exc_context2");

        // TLBR through masks, beating MTC0
        bus_if.mmu_pagemask = 32'hFFFF_FFFF; bus_if.mmu_entryhi = 32'h1111_22FF;
        bus_if.mmu_entrylo0 = 32'hFFFF_FFFF; bus_if.mmu_entrylo1 = 32'h4000_0001;
        bus_if.mtc0_we = 1'b1; bus_if.mtc0_addr = 5'd2; bus_if.mtc0_wdata = 32'h0;
        bus_if.tlbr = 1'b1;
        tick();
        bus_if.tlbr = 1'b0; bus_if.mtc0_we = 1'b0;
        chk("tlbr_entrylo0", bus_if.entrylo0, 32'h3FFF_FFFF);
        chk("tlbr_entrylo1", bus_if.entrylo1, 32'h0000_0001);
        chk("tlbr_pagemask", bus_if.pagemask, 32'h1FFF_E000);
        chk("tlbr_entryhi", bus_if.entryhi, 32'h1111_20FF);

        // Exception beats TLBR on EntryHi only
        bus_if.mmu_pagemask = 32'h0; bus_if.mmu_entryhi = 32'h0;
        bus_if.tlbr = 1'b1;
        exc(1'b1, 32'h0000_4000);
        bus_if.tlbr = 1'b0;
        chk("exc_over_tlbr", bus_if.entryhi, 32'h0000_40FF);
        chk("tlbr_pagemask2", bus_if.pagemask, 32'h0);

        // Asynchronous reset with strobes pending
        bus_if.mtc0_we = 1'b1; bus_if.mtc0_addr = 5'd6; bus_if.mtc0_wdata = 32'd3;
        bus_if.exc_tlb = 1'b1; bus_if.exc_vaddr = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_entryhi", bus_if.entryhi, 32'h0);
        chk("arst_index", bus_if.index, 32'h0);
        chk("arst_random", bus_if.random, 32'd31);
        rd(5'd8, 32'h0, "arst_badvaddr");
        tick();
        bus_if.mtc0_we = 1'b0; bus_if.exc_tlb = 1'b0;
        rst = 1'b0;
        rd(5'd6, 32'h0, "arst_wired");
        tick();
        chk("post_rst_random", bus_if.random, 32'd30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
